// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states, register map, CTRL fields.
// TIMER_PRESCALE_EN widens the writable CTRL field set to include the PS prescale value.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_PS_LSB   = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

`ifdef TIMER_PRESCALE_EN
    localparam logic [7:0] CTRL_WMASK = 8'hFF;
`else
    localparam logic [7:0] CTRL_WMASK = 8'h0F;
`endif

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator for the timer: tick_o is high on cycles where the prescale count equals PS.
// Present only when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [3:0] ps_i,
    output logic       tick_o
);

    logic [3:0] psc_q, psc_d;

    assign tick_o = (psc_q == ps_i);

    always_comb begin
        psc_d = psc_q;
        if (clr_i) begin
            psc_d = 4'd0;
        end else if (en_i) begin
            psc_d = tick_o ? 4'd0 : psc_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q <= 4'd0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule
`endif

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot and auto-reload modes and masked irq.
// Optional TIMER_PRESCALE_EN adds a CTRL.PS prescaler; otherwise COUNT steps every CNT cycle.
module timer_dev
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    state_e             state_q, state_d;
    logic [7:0]         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               flag_q, flag_d;

    logic               wr_ctrl, wr_preset;
    logic [7:0]         ctrl_wr;
    logic               en_eff;
    logic               tick;

    assign wr_ctrl   = sel && we && (addr == OFF_CTRL);
    assign wr_preset = sel && we && (addr == OFF_PRESET);
    assign ctrl_wr   = wd[7:0] & CTRL_WMASK;
    // A CTRL write acts on the FSM at the same edge it lands, so decisions use the incoming EN.
    assign en_eff    = wr_ctrl ? ctrl_wr[CTRL_EN] : ctrl_q[CTRL_EN];

`ifdef TIMER_PRESCALE_EN
    timer_prescaler u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == LOAD),
        .en_i   (state_q == CNT),
        .ps_i   (ctrl_q[CTRL_PS_LSB +: 4]),
        .tick_o (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        if (wr_ctrl) begin
            ctrl_d = ctrl_wr;
            flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = wd[CNT_W-1:0];
        end

        case (state_q)
            IDLE: begin
                if (en_eff) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en_eff) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (count_q > CNT_W'(1)) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        count_d = '0;
                        flag_d  = 1'b1;
                        state_d = INT;
                    end
                end
            end
            INT: begin
                if (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_RELOAD) begin
                    flag_d  = 1'b0;
                    state_d = en_eff ? LOAD : IDLE;
                end else begin
                    // Bus write wins over the one-shot auto-clear of EN.
                    if (!wr_ctrl) ctrl_d[CTRL_EN] = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ctrl_q   <= 8'd0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        rd = 32'd0;
        case (addr)
            OFF_CTRL:   rd[7:0]       = ctrl_q;
            OFF_PRESET: rd[CNT_W-1:0] = preset_q;
            OFF_COUNT:  rd[CNT_W-1:0] = count_q;
            default:    rd            = 32'd0;
        endcase
    end

    assign irq = ctrl_q[CTRL_IM] & flag_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: reset, one-shot, auto-reload, masking, pause/reprogram, prescale.
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int tests;
    int fails;

    int ar_cnt [4] = '{0, 2, 1, 0};
    int ps_cnt [7] = '{2, 2, 2, 1, 1, 1, 0};

    timer_dev #(.CNT_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .sel  (sel),
        .addr (addr),
        .we   (we),
        .wd   (wd),
        .rd   (rd),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd, exp);
    endtask

    task automatic ichk(input string tag, input logic exp);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    // Drive one bus write so it lands on the next rising edge; returns 1 time unit after that edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wd = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; wd = 32'd0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; wd = 32'd0;

        // Power-on reset state
        #2;
        rchk("rst_ctrl", 2'd0, 32'd0);
        rchk("rst_preset", 2'd1, 32'd0);
        rchk("rst_count", 2'd2, 32'd0);
        rchk("rst_rsvd", 2'd3, 32'd0);
        ichk("rst_irq", 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-count
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h1);
        step(4);
        rchk("mid_count5", 2'd2, 32'd5);
        rst = 1'b1;
        #1;
        rchk("mid_rst_ctrl", 2'd0, 32'd0);
        rchk("mid_rst_preset", 2'd1, 32'd0);
        rchk("mid_rst_count", 2'd2, 32'd0);
        rchk("mid_rst_rsvd", 2'd3, 32'd0);
        ichk("mid_rst_irq", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(3);
        rchk("post_rst_count", 2'd2, 32'd0);
        rchk("post_rst_ctrl", 2'd0, 32'd0);

        // One-shot, PRESET=3
        wr(2'd1, 32'd3);
        rchk("os_preset", 2'd1, 32'd3);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            rchk("os_count", 2'd2, 32'(4 - k));
            ichk("os_irq", k == 4);
        end
        step(1);
        rchk("os_ctrl_en_clr", 2'd0, 32'h8);
        ichk("os_irq_held", 1'b1);
        step(3);
        ichk("os_irq_held2", 1'b1);
        rchk("os_count_idle", 2'd2, 32'd0);
        wr(2'd0, 32'h8);
        ichk("os_irq_cleared", 1'b0);

        // Auto-reload, PRESET=2: period 4
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            rchk("ar_count", 2'd2, 32'(ar_cnt[k % 4]));
            ichk("ar_irq", (k % 4) == 3);
        end
        wr(2'd0, 32'h0);
        step(3);
        rchk("ar_stop_count", 2'd2, 32'd2);
        ichk("ar_stop_irq", 1'b0);

        // Masked expiry with PRESET=0
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        step(1);
        rchk("mask_count_load", 2'd2, 32'd0);
        step(1);
        ichk("mask_irq_int", 1'b0);
        step(1);
        rchk("mask_ctrl_en_clr", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        ichk("mask_irq_after_im", 1'b0);
        step(2);
        ichk("mask_irq_after_im2", 1'b0);

        // Pause and reprogram
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        step(5);
        rchk("pause_count6", 2'd2, 32'd6);
        wr(2'd0, 32'h0);
        rchk("pause_hold", 2'd2, 32'd6);
        step(3);
        rchk("pause_hold2", 2'd2, 32'd6);
        wr(2'd2, 32'h55);
        rchk("count_ro", 2'd2, 32'd6);
        wr(2'd1, 32'd4);
        rchk("preset_no_effect", 2'd2, 32'd6);
        wr(2'd0, 32'h1);
        step(1);
        rchk("reload_4", 2'd2, 32'd4);
        step(1);
        rchk("reload_3", 2'd2, 32'd3);
        wr(2'd3, 32'hFFFF_FFFF);
        rchk("rsvd_read0", 2'd3, 32'd0);
        wr(2'd0, 32'h0);
        step(2);

`ifdef TIMER_PRESCALE_EN
        // PS=2, PRESET=2, one-shot: irq 7 edges after the write
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h29);
        rchk("ps_ctrl", 2'd0, 32'h29);
        for (int k = 1; k <= 7; k++) begin
            step(1);
            rchk("ps_count", 2'd2, 32'(ps_cnt[k - 1]));
            ichk("ps_irq", k == 7);
        end
`else
        // PS bits are not writable; COUNT steps every cycle
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hF9);
        rchk("nops_ctrl", 2'd0, 32'h09);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            rchk("nops_count", 2'd2, 32'(3 - k));
            ichk("nops_irq", k == 3);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer on the CPU data bus; responds to the word accesses the M stage issues (address, write enable, write data) and returns read data.
- Raises an interrupt request when the count expires.
- Second device on the data bus alongside dm, selected by an external address decoder.
- Register access is single-cycle with no wait states.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers (1..32); upper read bits are zero-filled.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- sel  input  1  device selected by the bus decoder this cycle.
- addr  input  2  word offset (byte address bits [3:2]).
- we  input  1  write strobe; effective only when sel=1.
- wd  input  32  write data.
- rd  output  32  read data, combinational from addr.
- irq  output  1  interrupt request = CTRL.IM & irq_flag.

Behaviour:
- Register map (offset, access):
  - 0 CTRL (RW): bit0 EN, bits2:1 MODE, bit3 IM; other bits read 0.
  - 1 PRESET (RW).
  - 2 COUNT (RO; writes ignored).
  - 3 reserved (reads 0, writes ignored).
- Reset (async): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. rd follows addr; irq=0.
- rd is combinational and valid in the same cycle as addr. sel does not gate rd; the external mux handles selection.
- A write takes effect at the clock edge.
- A CTRL write clears irq_flag at the same edge.
- A PRESET write is used only at the next LOAD. It never alters a running count.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT:
    - EN=0 -> IDLE, COUNT frozen.
    - Else if COUNT>1: COUNT<=COUNT-1.
    - Else: COUNT<=0, irq_flag<=1, -> INT.
  - INT, MODE=00 (one-shot): EN<=0, -> IDLE. irq_flag stays set until a CTRL write or reset.
  - INT, MODE=01 (auto-reload): irq_flag<=0, -> LOAD. irq is a one-cycle pulse.
  - MODE=1x: behaves as 00.
- Latency: the edge that writes EN=1 enters LOAD. With PRESET=N (N>=1), irq rises N+1 edges after the write edge.
- Auto-reload period is N+2 cycles.
- PRESET=0 behaves as PRESET=1: LOAD -> CNT -> INT.
- Simultaneous bus write to CTRL and FSM auto-clear of EN in INT: the bus write wins for CTRL contents; the FSM still goes to IDLE/LOAD as defined.
- CTRL write with EN=0 in any state: the next edge goes to IDLE, except LOAD, which completes its load first.
- COUNT arithmetic is modulo 2^CNT_W. No underflow is possible, because counting stops at 0.

Optional Feature:
- TIMER_PRESCALE_EN defined:
  - CTRL bits7:4 become PS (RW).
  - A prescale counter is reset to 0 at LOAD.
  - In CNT, COUNT decrements only on cycles where the prescale counter equals PS; the prescale counter wraps to 0 at that point.
  - Expiry latency becomes 1 + N*(PS+1) edges after the write edge.
- Undefined: bits7:4 read 0 and writes are ignored; COUNT decrements every CNT cycle.

Decomposition:
- Package timer_pkg holds:
  - state encoding constants: IDLE=0, LOAD=1, CNT=2, INT=3;
  - register offsets: CTRL=0, PRESET=1, COUNT=2;
  - CTRL bit positions: EN, MODE, IM, PS;
  - MODE values: ONESHOT=00, RELOAD=01.
- One sub-module, timer_prescaler (tick generator), instantiated only under TIMER_PRESCALE_EN. Otherwise the tick is tied to 1.

Test Plan:
- Reset mid-count: with COUNT=5 in CNT, assert rst -> immediately COUNT=0, irq=0, state IDLE, all reads 0.
- One-shot: PRESET=3, write CTRL=0x9 (EN, IM, MODE 00) -> COUNT reads 3,2,1,0 on the following edges; irq=1 on edge 4 after the write and held; CTRL reads 0x8; a later CTRL write of 0x8 drops irq.
- Auto-reload: PRESET=2, CTRL=0xB -> irq pulses exactly one cycle every 4 cycles for 3 periods; COUNT sequence 2,1,0,(LOAD),2,...
- Masking and edge cases: PRESET=0 with CTRL=0x1 (IM=0) -> INT reached in 2 edges, irq stays 0; then CTRL=0x8 -> irq stays 0 and irq_flag is cleared.
- Pause and reprogram: running PRESET=10, write CTRL EN=0 at COUNT=6 -> COUNT holds 6 in IDLE; write PRESET=4, then EN=1 -> reload to 4. A COUNT write of 0x55 is ignored.
- TIMER_PRESCALE_EN: PS=2, PRESET=2, one-shot -> COUNT decrements every 3 cycles; irq rises 7 edges after the write.
